perf_event_unit: RTL and testbench
==================================

PERF_EVENT_UNIT -- requirements
Module: perf_event_unit

Interface
REQ-001 Parameter: CNT_W, 64, width of every event counter.
REQ-002 Parameter: LAT_W, 16, width of LSU max-latency register.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 ifu_valid  input  1  IFU presents instruction.
REQ-006 idu_ready  input  1  IDU accepts instruction.
REQ-007 icache_start  input  1  icache memory refill started (level).
REQ-008 icache_valid  input  1  icache delivers fetch result (level).
REQ-009 icache_isHit  input  1  current icache access hit.
REQ-010 lsu_ren / lsu_wen  input  1 each  LSU load / store request.
REQ-011 lsu_isWaiting  input  1  LSU blocked on memory.
REQ-012 freeze  input  1  hold all counters.
REQ-013 clear  input  1  synchronous zero of all counters.
REQ-014 rd_en  input  1  read request.
REQ-015 rd_addr  input  5  read address.
REQ-016 rd_valid  output  1  read data valid.
REQ-017 rd_data  output  32  read data.

Function
REQ-018 Rising edge of X SHALL mean X=1 this cycle and X=0 in registered previous cycle.
REQ-019 Counter map SHALL be: 0 cycles (every cycle), 1 ifu_fire (ifu_valid&idu_ready), 2 ic_hit, 3 ic_miss, 4 ic_refill_cyc, 5 lsu_load, 6 lsu_store, 7 lsu_wait_cyc.
REQ-020 ic_hit/ic_miss SHALL increment by 1 on icache_valid rising edge per icache_isHit that cycle.
REQ-021 Icache FSM SHALL have states IC_IDLE, IC_REFILL; IC_IDLE->IC_REFILL on icache_start rising edge; IC_REFILL->IC_IDLE on cycle icache_valid=1; ic_refill_cyc increments every cycle in IC_REFILL.
REQ-022 Start rise and valid=1 in same cycle SHALL leave FSM in IC_IDLE, refill counted 0 cycles.
REQ-023 LSU FSM SHALL have states L_IDLE, L_WAIT; L_IDLE->L_WAIT on lsu_isWaiting rising edge; L_WAIT->L_IDLE when lsu_isWaiting=0.
REQ-024 On L_IDLE->L_WAIT, lsu_load SHALL increment if lsu_ren, lsu_store if lsu_wen, both if both, neither if neither.
REQ-025 lsu_wait_cyc and a LAT_W-bit current-latency counter SHALL increment every cycle in L_WAIT; latency counter saturates at all-ones, clears on entry to L_WAIT.
REQ-026 On L_WAIT->L_IDLE, lsu_max_lat SHALL update to current latency if greater.
REQ-027 Counters SHALL wrap modulo 2^CNT_W without flag.
REQ-028 freeze=1 SHALL hold counters and lsu_max_lat; FSMs and edge registers keep tracking.
REQ-029 clear=1 SHALL zero counters, lsu_max_lat, snapshot next edge; clear beats same-cycle increment and freeze; FSM state unaffected.
REQ-030 Read latency SHALL be one cycle: rd_en at cycle t -> rd_valid=1 and rd_data at t+1; rd_valid=0 otherwise, rd_data 0 when rd_valid=0.
REQ-031 rd_addr[4]=0: index=rd_addr[3:1]; rd_addr[0]=0 returns counter[31:0] and captures counter[63:32] into snapshot; rd_addr[0]=1 returns snapshot.
REQ-032 rd_addr=16 SHALL return lsu_max_lat zero-extended; 17 returns {30'b0, lsu FSM==L_WAIT, icache FSM==IC_REFILL}; 18-31 return 0.
REQ-033 Read returns pre-increment value of cycle t.

Reset
REQ-034 reset=0 SHALL zero all counters, snapshot, lsu_max_lat, latency counter, edge registers, rd_valid, rd_data; FSMs to IC_IDLE/L_IDLE.
REQ-035 Reset mid-refill or mid-wait SHALL abandon the transaction without updating lsu_max_lat; an input high on first post-reset cycle counts as a rising edge.

Structure
REQ-036 Shared package perf_pkg SHALL hold counter index constants, read address constants, and IC/LSU FSM state enums.
REQ-037 Sub-module perf_counter (CNT_W counter with inc, freeze, clear) SHALL be instantiated 8 times.

Verification
REQ-038 Reset release, 100 idle cycles, read addr 0 then 1 -> 100 low, 0 high.
REQ-039 icache_start rise, valid 5 cycles later with isHit=0 -> ic_miss=1, ic_refill_cyc=5, ic_hit=0.
REQ-040 lsu_ren=1 waits 3 cycles, then lsu_wen=1 waits 7 -> lsu_load=1, lsu_store=1, lsu_wait_cyc=10, addr 16 reads 7.
REQ-041 Preload cycles to 0xFFFFFFFF_FFFFFFFE, run 3 cycles -> read low 1, high 0 (wrap).
REQ-042 clear and ifu_fire same cycle -> counter 1 reads 0; freeze 10 cycles -> cycles unchanged.
REQ-043 Low read of counter 0 then 2^32 cycles then high read -> returns captured high, not live.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared definitions for the performance event unit: counter map, read map, FSM states.
package perf_pkg;

  localparam int unsigned NUM_CNT = 8;

  localparam int unsigned CNT_CYCLES    = 0;
  localparam int unsigned CNT_IFU_FIRE  = 1;
  localparam int unsigned CNT_IC_HIT    = 2;
  localparam int unsigned CNT_IC_MISS   = 3;
  localparam int unsigned CNT_IC_REFILL = 4;
  localparam int unsigned CNT_LSU_LOAD  = 5;
  localparam int unsigned CNT_LSU_STORE = 6;
  localparam int unsigned CNT_LSU_WAIT  = 7;

  localparam logic [4:0] ADDR_MAX_LAT = 5'd16;
  localparam logic [4:0] ADDR_STATUS  = 5'd17;

  typedef enum logic {IC_IDLE, IC_REFILL} ic_state_t;
  typedef enum logic {L_IDLE, L_WAIT} lsu_state_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with hold and synchronous clear; wraps silently.
module perf_counter #(
  parameter int unsigned      CNT_W = 64,
  parameter logic [CNT_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             freeze,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset)
      count <= INIT;
    else if (clear)
      count <= '0;
    else if (inc && !freeze)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/perf_event_unit.sv
// Performance event unit: eight event counters, icache/LSU tracking FSMs and a
// one-cycle-latency read port with a high-word snapshot for 64-bit reads.
module perf_event_unit
  import perf_pkg::*;
#(
  parameter int unsigned      CNT_W       = 64,
  parameter int unsigned      LAT_W       = 16,
  parameter logic [CNT_W-1:0] CYCLES_INIT = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_valid,
  input  logic        idu_ready,
  input  logic        icache_start,
  input  logic        icache_valid,
  input  logic        icache_isHit,
  input  logic        lsu_ren,
  input  logic        lsu_wen,
  input  logic        lsu_isWaiting,
  input  logic        freeze,
  input  logic        clear,
  input  logic        rd_en,
  input  logic [4:0]  rd_addr,
  output logic        rd_valid,
  output logic [31:0] rd_data
);

  logic start_q, valid_q, wait_q;
  logic start_rise, valid_rise, wait_rise;

  ic_state_t  ic_state, ic_next;
  lsu_state_t lsu_state, lsu_next;
  logic       lsu_enter, lsu_exit;

  logic [LAT_W-1:0] cur_lat, lat_next, max_lat;

  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [CNT_W-1:0]   cnt_sel;
  logic [31:0]        snap;
  logic [31:0]        rd_word;

  assign start_rise = icache_start  & ~start_q;
  assign valid_rise = icache_valid  & ~valid_q;
  assign wait_rise  = lsu_isWaiting & ~wait_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      wait_q    <= 1'b0;
      ic_state  <= IC_IDLE;
      lsu_state <= L_IDLE;
    end else begin
      start_q   <= icache_start;
      valid_q   <= icache_valid;
      wait_q    <= lsu_isWaiting;
      ic_state  <= ic_next;
      lsu_state <= lsu_next;
    end
  end

  // A start edge that coincides with the result never opens a refill window.
  always_comb begin
    ic_next = ic_state;
    unique case (ic_state)
      IC_IDLE:   if (start_rise && !icache_valid) ic_next = IC_REFILL;
      IC_REFILL: if (icache_valid) ic_next = IC_IDLE;
      default:   ic_next = IC_IDLE;
    endcase
  end

  always_comb begin
    lsu_next  = lsu_state;
    lsu_enter = 1'b0;
    lsu_exit  = 1'b0;
    unique case (lsu_state)
      L_IDLE: if (wait_rise) begin
        lsu_next  = L_WAIT;
        lsu_enter = 1'b1;
      end
      L_WAIT: if (!lsu_isWaiting) begin
        lsu_next = L_IDLE;
        lsu_exit = 1'b1;
      end
      default: lsu_next = L_IDLE;
    endcase
  end

  // The exit cycle is itself a wait cycle, so the recorded latency includes it.
  assign lat_next = (&cur_lat) ? cur_lat : cur_lat + LAT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_lat <= '0;
      max_lat <= '0;
    end else begin
      if (lsu_enter)
        cur_lat <= '0;
      else if (lsu_state == L_WAIT)
        cur_lat <= lat_next;
      if (clear)
        max_lat <= '0;
      else if (!freeze && lsu_exit && (lat_next > max_lat))
        max_lat <= lat_next;
    end
  end

  always_comb begin
    inc                = '0;
    inc[CNT_CYCLES]    = 1'b1;
    inc[CNT_IFU_FIRE]  = ifu_valid & idu_ready;
    inc[CNT_IC_HIT]    = valid_rise & icache_isHit;
    inc[CNT_IC_MISS]   = valid_rise & ~icache_isHit;
    inc[CNT_IC_REFILL] = (ic_state == IC_REFILL);
    inc[CNT_LSU_LOAD]  = lsu_enter & lsu_ren;
    inc[CNT_LSU_STORE] = lsu_enter & lsu_wen;
    inc[CNT_LSU_WAIT]  = (lsu_state == L_WAIT);
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_counter #(
      .CNT_W (CNT_W),
      .INIT  ((i == CNT_CYCLES) ? CYCLES_INIT : '0)
    ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (inc[i]),
      .freeze (freeze),
      .clear  (clear),
      .count  (cnt[i])
    );
  end

  assign cnt_sel = cnt[rd_addr[3:1]];

  always_comb begin
    rd_word = '0;
    if (!rd_addr[4])
      rd_word = rd_addr[0] ? snap : cnt_sel[31:0];
    else if (rd_addr == ADDR_MAX_LAT)
      rd_word = 32'(max_lat);
    else if (rd_addr == ADDR_STATUS)
      rd_word = {30'b0, lsu_state == L_WAIT, ic_state == IC_REFILL};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      snap     <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_word : '0;
      if (clear)
        snap <= '0;
      else if (rd_en && !rd_addr[4] && !rd_addr[0])
        snap <= 32'(cnt_sel >> 32);
    end
  end

endmodule

// File: tb/tb_perf_event_unit.sv
// Bench for perf_event_unit: directed scenarios plus random traffic against an event-level model.
module tb_perf_event_unit;

  localparam logic [63:0] WRAP_INIT = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam int unsigned LAT_MAX   = 65535;

  logic        clk = 1'b0;
  logic        reset, ifu_valid, idu_ready, icache_start, icache_valid, icache_isHit;
  logic        lsu_ren, lsu_wen, lsu_isWaiting, freeze, clear, rd_en;
  logic [4:0]  rd_addr;
  logic        rd_valid_a, rd_valid_b;
  logic [31:0] rd_data_a, rd_data_b;

  int unsigned pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

  // Reference state: counts per DUT (only the cycle counter start differs).
  longint unsigned m_cnt [2][8];
  logic [31:0]     m_snap [2];
  int unsigned     m_cur_lat, m_max_lat;
  bit              ic_busy, lsu_busy, p_start, p_valid, p_wait;

  always #5 clk = ~clk;

  perf_event_unit u_dut (
    .clk(clk), .reset(reset), .ifu_valid(ifu_valid), .idu_ready(idu_ready),
    .icache_start(icache_start), .icache_valid(icache_valid), .icache_isHit(icache_isHit),
    .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_isWaiting(lsu_isWaiting),
    .freeze(freeze), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a)
  );

  perf_event_unit #(.CYCLES_INIT(WRAP_INIT)) u_wrap (
    .clk(clk), .reset(reset), .ifu_valid(ifu_valid), .idu_ready(idu_ready),
    .icache_start(icache_start), .icache_valid(icache_valid), .icache_isHit(icache_isHit),
    .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_isWaiting(lsu_isWaiting),
    .freeze(freeze), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [4:0] a);
    longint unsigned v;
    if (a < 16) begin
      v = m_cnt[d][a[3:1]];
      return a[0] ? m_snap[d] : v[31:0];
    end
    if (a == 16) return m_max_lat;
    if (a == 17) return {30'b0, lsu_busy, ic_busy};
    return 32'd0;
  endfunction

  task automatic model_step();
    bit sr, vr, wr, enter, leave;
    int unsigned lat;
    bit [7:0] ev;
    longint unsigned v;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 8; i++) m_cnt[d][i] = 0;
        m_snap[d] = '0;
      end
      m_cnt[1][0] = WRAP_INIT;
      m_cur_lat = 0; m_max_lat = 0;
      ic_busy = 0; lsu_busy = 0; p_start = 0; p_valid = 0; p_wait = 0;
      return;
    end
    sr    = icache_start && !p_start;
    vr    = icache_valid && !p_valid;
    wr    = lsu_isWaiting && !p_wait;
    enter = !lsu_busy && wr;
    leave = lsu_busy && !lsu_isWaiting;
    lat   = (m_cur_lat >= LAT_MAX) ? LAT_MAX : m_cur_lat + 1;
    ev    = {lsu_busy, enter && lsu_wen, enter && lsu_ren, ic_busy,
             vr && !icache_isHit, vr && icache_isHit, ifu_valid && idu_ready, 1'b1};
    for (int d = 0; d < 2; d++) begin
      if (clear) begin
        for (int i = 0; i < 8; i++) m_cnt[d][i] = 0;
        m_snap[d] = '0;
      end else begin
        if (rd_en && rd_addr < 16 && !rd_addr[0]) begin
          v = m_cnt[d][rd_addr[3:1]];
          m_snap[d] = v[63:32];
        end
        if (!freeze)
          for (int i = 0; i < 8; i++) if (ev[i]) m_cnt[d][i] = m_cnt[d][i] + 1;
      end
    end
    if (clear) m_max_lat = 0;
    else if (!freeze && leave && lat > m_max_lat) m_max_lat = lat;
    if (enter) m_cur_lat = 0;
    else if (lsu_busy) m_cur_lat = lat;
    ic_busy  = ic_busy ? !icache_valid : (sr && !icache_valid);
    lsu_busy = lsu_busy ? lsu_isWaiting : wr;
    p_start = icache_start; p_valid = icache_valid; p_wait = lsu_isWaiting;
  endtask

  // One clock: predict the read result, advance the model, then compare after the edge.
  task automatic cycle();
    logic [31:0] exp_a, exp_b;
    logic        exp_v;
    exp_v = rd_en && reset;
    exp_a = exp_v ? model_read(0, rd_addr) : 32'd0;
    exp_b = exp_v ? model_read(1, rd_addr) : 32'd0;
    model_step();
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid_a), 32'(exp_v));
    chk("rd_data", rd_data_a, exp_a);
    chk("wrap_rd_valid", 32'(rd_valid_b), 32'(exp_v));
    chk("wrap_rd_data", rd_data_b, exp_b);
  endtask

  task automatic quiet();
    ifu_valid = 0; idu_ready = 0; icache_start = 0; icache_valid = 0; icache_isHit = 0;
    lsu_ren = 0; lsu_wen = 0; lsu_isWaiting = 0; freeze = 0; clear = 0;
    rd_en = 0; rd_addr = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] da, output logic [31:0] db);
    rd_en = 1; rd_addr = a;
    cycle();
    da = rd_data_a; db = rd_data_b;
    rd_en = 0; rd_addr = '0;
  endtask

  task automatic do_reset(input int n);
    reset = 0;
    idle(n);
    reset = 1;
  endtask

  initial begin
    logic [31:0] da, db;
    quiet();
    reset = 0;
    do_reset(3);

    // Wrap: cycle counter preloaded just below 2^64 in the second instance.
    rd(5'd0, da, db);   chk("wrap_lo_start", db, 32'hFFFF_FFFE);
    idle(2);
    rd(5'd0, da, db);   chk("wrap_lo_after", db, 32'd1);
    chk("cycles_lo_3", da, 32'd3);
    rd(5'd1, da, db);   chk("wrap_hi_after", db, 32'd0);

    // Snapshot holds the high word captured before the wrap.
    do_reset(2);
    rd(5'd0, da, db);
    idle(4);
    rd(5'd1, da, db);   chk("snap_not_live", db, 32'hFFFF_FFFF);

    // Reset release then 100 idle cycles.
    do_reset(2);
    idle(100);
    rd(5'd0, da, db);   chk("cycles_lo_100", da, 32'd100);
    rd(5'd1, da, db);   chk("cycles_hi_100", da, 32'd0);
    rd(5'd16, da, db);  chk("max_lat_reset", da, 32'd0);
    rd(5'd17, da, db);  chk("status_reset", da, 32'd0);
    rd(5'd6, da, db);   chk("ic_miss_reset", da, 32'd0);

    // Icache miss with a five-cycle refill window.
    clear = 1; cycle(); clear = 0;
    icache_start = 1; cycle();
    cycle();
    rd(5'd17, da, db);  chk("status_refill", da, 32'd1);
    idle(2);
    icache_valid = 1; icache_isHit = 0; cycle();
    quiet(); cycle();
    rd(5'd4, da, db);   chk("ic_hit", da, 32'd0);
    rd(5'd6, da, db);   chk("ic_miss", da, 32'd1);
    rd(5'd8, da, db);   chk("ic_refill_cyc", da, 32'd5);

    // Same-cycle start edge and result: no refill window.
    icache_start = 1; icache_valid = 1; icache_isHit = 1; cycle();
    quiet(); cycle();
    rd(5'd8, da, db);   chk("ic_refill_same", da, 32'd5);
    rd(5'd4, da, db);   chk("ic_hit_same", da, 32'd1);

    // LSU load waiting 3 cycles, store waiting 7 cycles.
    clear = 1; cycle(); clear = 0;
    lsu_ren = 1; lsu_isWaiting = 1; idle(3);
    lsu_ren = 0; lsu_isWaiting = 0; idle(2);
    lsu_wen = 1; lsu_isWaiting = 1; idle(3);
    rd(5'd17, da, db);  chk("status_lsu_wait", da, 32'd2);
    idle(3);
    lsu_wen = 0; lsu_isWaiting = 0; idle(2);
    rd(5'd10, da, db);  chk("lsu_load", da, 32'd1);
    rd(5'd12, da, db);  chk("lsu_store", da, 32'd1);
    rd(5'd14, da, db);  chk("lsu_wait_cyc", da, 32'd10);
    rd(5'd16, da, db);  chk("lsu_max_lat", da, 32'd7);

    // Clear beats a same-cycle ifu_fire; freeze holds the cycle counter.
    ifu_valid = 1; idu_ready = 1; clear = 1; cycle();
    quiet();
    rd(5'd2, da, db);   chk("ifu_fire_clear", da, 32'd0);
    rd(5'd16, da, db);  chk("max_lat_clear", da, 32'd0);
    idle(3);
    freeze = 1; ifu_valid = 1; idu_ready = 1; idle(10);
    rd(5'd0, da, db);   chk("cycles_frozen", da, 32'd5);
    rd(5'd2, da, db);   chk("ifu_frozen", da, 32'd0);
    quiet();
    clear = 1; freeze = 1; cycle(); quiet();
    rd(5'd0, da, db);   chk("clear_beats_freeze", da, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      reset        = ($urandom_range(0, 299) != 0);
      ifu_valid    = $urandom_range(0, 1);
      idu_ready    = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) icache_start = ~icache_start;
      if ($urandom_range(0, 3) == 0) icache_valid = ~icache_valid;
      icache_isHit = $urandom_range(0, 1);
      lsu_ren      = $urandom_range(0, 1);
      lsu_wen      = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) lsu_isWaiting = ~lsu_isWaiting;
      freeze       = ($urandom_range(0, 7) == 0);
      clear        = ($urandom_range(0, 63) == 0);
      rd_en        = $urandom_range(0, 1);
      rd_addr      = 5'($urandom_range(0, 31));
      cycle();
    end
    quiet();
    reset = 1;
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
